// File: rtl/reverse_polish_notation.sv
// Serial-command RPN calculator: one-wire command frames drive an operand stack; enter
// serialises the top of stack onto dOut. Define RPN_SATURATE_EN to clamp add/mult results.
module reverse_polish_notation #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic dIn,
  output logic dOut
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {DEC_IDLE, DEC_OP1, DEC_DATA, DEC_OP2, DEC_OP3} dec_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_SEP, TX_DATA} tx_state_e;

  function automatic logic [WIDTH-1:0] rpn_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
`ifdef RPN_SATURATE_EN
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    rpn_add = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    rpn_add = a + b;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] rpn_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
`ifdef RPN_SATURATE_EN
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    rpn_mul = (|prod[2*WIDTH-1:WIDTH]) ? {WIDTH{1'b1}} : prod[WIDTH-1:0];
`else
    rpn_mul = a * b;
`endif
  endfunction

  dec_state_e         dec_state_q, dec_state_d;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [WIDTH-2:0]   shift_q;
  logic               b2_q;
  logic [WIDTH-1:0]   push_val_s;
  logic               push_s, clear_s, add_s, mult_s, enter_s;

  logic [WIDTH-1:0]   stack_q [DEPTH];
  logic [SP_W-1:0]    sp_q;
  logic [IDX_W-1:0]   top_idx_s, sec_idx_s, push_idx_s;
  logic               full_s, empty_s, two_s;

  tx_state_e          tx_state_q, tx_state_d;
  logic [CNT_W-1:0]   tx_cnt_q;
  logic [WIDTH-1:0]   tx_shift_q;
  logic               dout_q, dout_d;

  // Decoder state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dec_state_q <= DEC_IDLE;
    else      dec_state_q <= dec_state_d;
  end

  // Decoder next-state logic, one transition per sampled bit
  always_comb begin
    dec_state_d = dec_state_q;
    case (dec_state_q)
      DEC_IDLE: dec_state_d = dIn ? DEC_OP1 : DEC_IDLE;
      DEC_OP1:  dec_state_d = dIn ? DEC_OP2 : DEC_DATA;
      DEC_DATA: dec_state_d = (bit_cnt_q == CNT_W'(WIDTH - 1)) ? DEC_IDLE : DEC_DATA;
      DEC_OP2:  dec_state_d = DEC_OP3;
      DEC_OP3:  dec_state_d = DEC_IDLE;
      default:  dec_state_d = DEC_IDLE;
    endcase
  end

  // Decoder command strobes, asserted on the cycle carrying the last command bit
  always_comb begin
    push_s  = 1'b0;
    clear_s = 1'b0;
    add_s   = 1'b0;
    mult_s  = 1'b0;
    enter_s = 1'b0;
    if (dec_state_q == DEC_DATA) begin
      push_s = (bit_cnt_q == CNT_W'(WIDTH - 1));
    end else if (dec_state_q == DEC_OP3) begin
      case ({b2_q, dIn})
        2'b00:   clear_s = 1'b1;
        2'b01:   add_s   = 1'b1;
        2'b10:   mult_s  = 1'b1;
        2'b11:   enter_s = 1'b1;
        default: clear_s = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  assign push_val_s = {shift_q, dIn};

  // Data bit collection and opcode bit capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      b2_q      <= 1'b0;
    end else begin
      if (dec_state_q == DEC_DATA) begin
        shift_q   <= push_val_s[WIDTH-2:0];
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end else begin
        bit_cnt_q <= '0;
      end
      if (dec_state_q == DEC_OP2) b2_q <= dIn;
    end
  end

  assign top_idx_s  = IDX_W'(sp_q - SP_W'(1));
  assign sec_idx_s  = IDX_W'(sp_q - SP_W'(2));
  assign push_idx_s = IDX_W'(sp_q);
  assign full_s     = (sp_q == SP_W'(DEPTH));
  assign empty_s    = (sp_q == SP_W'(0));
  assign two_s      = (sp_q >= SP_W'(2));

  // Operand stack; binary ops write the result over the second entry and drop one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else if (clear_s) begin
      sp_q <= '0;
    end else if (push_s && !full_s) begin
      stack_q[push_idx_s] <= push_val_s;
      sp_q                <= sp_q + SP_W'(1);
    end else if (add_s && two_s) begin
      stack_q[sec_idx_s] <= rpn_add(stack_q[top_idx_s], stack_q[sec_idx_s]);
      sp_q               <= sp_q - SP_W'(1);
    end else if (mult_s && two_s) begin
      stack_q[sec_idx_s] <= rpn_mul(stack_q[top_idx_s], stack_q[sec_idx_s]);
      sp_q               <= sp_q - SP_W'(1);
    end
  end

  // Transmitter state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state_q <= TX_IDLE;
    else      tx_state_q <= tx_state_d;
  end

  // Transmitter next-state logic; an enter arriving while busy is dropped
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  tx_state_d = (enter_s && !empty_s) ? TX_START : TX_IDLE;
      TX_START: tx_state_d = TX_SEP;
      TX_SEP:   tx_state_d = TX_DATA;
      TX_DATA:  tx_state_d = (tx_cnt_q == CNT_W'(WIDTH - 1)) ? TX_IDLE : TX_DATA;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // Transmitter line value for the next cycle
  always_comb begin
    dout_d = 1'b0;
    case (tx_state_q)
      TX_START: dout_d = 1'b1;
      TX_DATA:  dout_d = tx_shift_q[WIDTH-1];
      default:  dout_d = 1'b0;
    endcase
  end

  // Frame payload latch, bit counter and registered output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      dout_q     <= 1'b0;
    end else begin
      dout_q <= dout_d;
      if (tx_state_q == TX_IDLE && tx_state_d == TX_START) begin
        tx_shift_q <= stack_q[top_idx_s];
      end else if (tx_state_q == TX_DATA) begin
        tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
      end
      if (tx_state_q == TX_DATA) tx_cnt_q <= tx_cnt_q + CNT_W'(1);
      else                       tx_cnt_q <= '0;
    end
  end

  assign dOut = dout_q;

endmodule

// File: tb/tb_reverse_polish_notation.sv
// Directed bench for reverse_polish_notation: serial commands in, captured result frames checked.
module tb_reverse_polish_notation;

  logic clk;
  logic rst;
  logic dIn;
  logic dOut;
  int   checks;
  int   errors;

  reverse_polish_notation dut (
    .clk  (clk),
    .rst  (rst),
    .dIn  (dIn),
    .dOut (dOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [7:0] obs, input logic [7:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    dIn = b;
    @(posedge clk);
    #1;
    dIn = 1'b0;
  endtask

  task automatic push(input logic [7:0] v);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic cmd(input logic [1:0] op);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(op[1]);
    send_bit(op[0]);
  endtask

  task automatic enter_expect(input logic [7:0] exp, input string tag);
    logic [7:0] got;
    got = 8'd0;
    cmd(2'b11);
    @(posedge clk); #1;
    check({7'd0, dOut}, 8'd1, {tag, "_start"});
    @(posedge clk); #1;
    check({7'd0, dOut}, 8'd0, {tag, "_sep"});
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      got = {got[6:0], dOut};
    end
    check(got, exp, {tag, "_data"});
    @(posedge clk); #1;
    check({7'd0, dOut}, 8'd0, {tag, "_idle"});
  endtask

  task automatic enter_no_frame(input string tag);
    int ones;
    ones = 0;
    cmd(2'b11);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dOut) ones++;
    end
    check(8'(ones), 8'd0, tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    dIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({7'd0, dOut}, 8'd0, "reset_dout");
    rst = 1'b1;
    @(posedge clk); #1;
    enter_no_frame("reset_empty");

    // Test 1
    for (int v = 1; v <= 5; v++) push(8'(v));
    enter_expect(8'd5, "t1_top");
    cmd(2'b01);
    enter_expect(8'd9, "t1_add");
    cmd(2'b10);
    enter_expect(8'd27, "t1_mult");

    // Test 2
    cmd(2'b00);
    for (int v = 6; v <= 20; v += 2) push(8'(v));
    repeat (4) cmd(2'b01);
    enter_expect(8'd80, "t2_add4");
    push(8'd2);
    cmd(2'b10);
    enter_expect(8'd160, "t2_mult");

    // Test 3
    push(8'd0);
    cmd(2'b10);
    enter_expect(8'd0, "t3_mult0");
    push(8'd254);
    push(8'd1);
    cmd(2'b01);
    enter_expect(8'd255, "t3_add255");

    // Test 4
    cmd(2'b00);
    push(8'd7);
    push(8'd9);
    push(8'd2);
    cmd(2'b10);
    cmd(2'b10);
    enter_expect(8'd126, "t4_mult2");
    for (int v = 1; v <= 7; v++) push(8'(v));
    enter_expect(8'd7, "t4_full_top");
    push(8'd99);
    enter_expect(8'd7, "t4_overflow");

    // Test 5
    cmd(2'b00);
    enter_no_frame("t5_empty");
    push(8'd5);
    cmd(2'b01);
    enter_expect(8'd5, "t5_underflow");

    // Test 6
    push(8'd200);
    push(8'd100);
    cmd(2'b01);
`ifdef RPN_SATURATE_EN
    enter_expect(8'd255, "t6_sat");
`else
    enter_expect(8'd44, "t6_wrap");
`endif

    // Reset in the middle of an output frame; bit d5 of the top value is 1
    cmd(2'b11);
    repeat (5) @(posedge clk);
    #1;
    check({7'd0, dOut}, 8'd1, "t6_midframe_bit");
    rst = 1'b0;
    #1;
    check({7'd0, dOut}, 8'd0, "t6_rst_dout");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    enter_no_frame("t6_rst_empty");
    push(8'd3);
    enter_expect(8'd3, "t6_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
